// File: rtl/branch_pkg.sv
// +-----------------------------------------------------------------------+
// | branch_pkg: shared encodings and helpers for branch_cmp_seq           |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic int nchunk(input int xlen, input int chunk);
    return xlen / chunk;
  endfunction

  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

  function automatic logic f3_taken(input logic [2:0] f3, input logic eq, input logic lt);
    logic t;
    case (f3)
      F3_BEQ:           t = eq;
      F3_BNE:           t = !eq;
      F3_BLT, F3_BLTU:  t = lt;
      F3_BGE, F3_BGEU:  t = !lt;
      default:          t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_cmp_seq_if.sv
// +-----------------------------------------------------------------------+
// | branch_cmp_seq_if: request/result handshake bundle                    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

interface branch_cmp_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [2:0]      funct3;
  logic            out_valid;
  logic            out_ready;
  logic            taken;
  logic            br_eq;
  logic            br_lt;
  logic            illegal;

  modport master (
    output in_valid, rs1, rs2, funct3, out_ready,
    input  in_ready, out_valid, taken, br_eq, br_lt, illegal
  );

  modport slave (
    input  in_valid, rs1, rs2, funct3, out_ready,
    output in_ready, out_valid, taken, br_eq, br_lt, illegal
  );
endinterface

`default_nettype wire

// File: rtl/branch_chunk_cmp.sv
// +-----------------------------------------------------------------------+
// | branch_chunk_cmp: combinational WIDTH-bit unsigned magnitude compare  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module branch_chunk_cmp #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             lt
);
  assign gt = (a > b);
  assign lt = (a < b);
endmodule

`default_nettype wire

// File: rtl/branch_cmp_seq.sv
// +-----------------------------------------------------------------------+
// | branch_cmp_seq: multi-cycle RV branch resolver, CHUNK bits per cycle  |
// | Optional macro BRANCH_CMP_EARLY_OUT_EN: leave CMP on first decision.  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module branch_cmp_seq
  import branch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  logic clk,
  input  logic rst,
  branch_cmp_seq_if.slave bus
);

  localparam int NCHUNK = nchunk(XLEN, CHUNK);
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_TOP = KW'(NCHUNK - 1);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]      f3_q, f3_d;
  logic [KW-1:0]   k_q, k_d;
  logic            taken_q, taken_d;
  logic            br_eq_q, br_eq_d;
  logic            br_lt_q, br_lt_d;
  logic            illegal_q, illegal_d;
`ifndef BRANCH_CMP_EARLY_OUT_EN
  logic            dec_q, dec_d;
  logic            lt_acc_q, lt_acc_d;
`endif

  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic             chunk_gt, chunk_lt;
  logic             req_fire;
  logic             fin_lt, fin_eq;

  assign a_chunk = a_q[int'(k_q) * CHUNK +: CHUNK];
  assign b_chunk = b_q[int'(k_q) * CHUNK +: CHUNK];

  branch_chunk_cmp #(.WIDTH(CHUNK)) u_chunk_cmp (
    .a  (a_chunk),
    .b  (b_chunk),
    .gt (chunk_gt),
    .lt (chunk_lt)
  );

  assign req_fire = bus.in_valid && (state_q == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      f3_q      <= '0;
      k_q       <= '0;
      taken_q   <= 1'b0;
      br_eq_q   <= 1'b0;
      br_lt_q   <= 1'b0;
      illegal_q <= 1'b0;
`ifndef BRANCH_CMP_EARLY_OUT_EN
      dec_q     <= 1'b0;
      lt_acc_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      f3_q      <= f3_d;
      k_q       <= k_d;
      taken_q   <= taken_d;
      br_eq_q   <= br_eq_d;
      br_lt_q   <= br_lt_d;
      illegal_q <= illegal_d;
`ifndef BRANCH_CMP_EARLY_OUT_EN
      dec_q     <= dec_d;
      lt_acc_q  <= lt_acc_d;
`endif
    end
  end

  // A decided verdict (lt or gt) from an earlier chunk overrides the current one.
  always_comb begin
`ifdef BRANCH_CMP_EARLY_OUT_EN
    fin_lt = chunk_lt;
    fin_eq = !chunk_gt && !chunk_lt;
`else
    fin_lt = dec_q ? lt_acc_q : chunk_lt;
    fin_eq = !dec_q && !chunk_gt && !chunk_lt;
`endif
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    f3_d      = f3_q;
    k_d       = k_q;
    taken_d   = taken_q;
    br_eq_d   = br_eq_q;
    br_lt_d   = br_lt_q;
    illegal_d = illegal_q;
`ifndef BRANCH_CMP_EARLY_OUT_EN
    dec_d     = dec_q;
    lt_acc_d  = lt_acc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_fire) begin
          // Flipping both sign bits maps signed order onto unsigned order.
          a_d  = bus.rs1;
          b_d  = bus.rs2;
          if (!bus.funct3[1]) begin
            a_d[XLEN-1] = ~bus.rs1[XLEN-1];
            b_d[XLEN-1] = ~bus.rs2[XLEN-1];
          end
          f3_d = bus.funct3;
          k_d  = K_TOP;
`ifndef BRANCH_CMP_EARLY_OUT_EN
          dec_d    = 1'b0;
          lt_acc_d = 1'b0;
`endif
          if (f3_illegal(bus.funct3)) begin
            state_d   = S_DONE;
            illegal_d = 1'b1;
            taken_d   = 1'b0;
            br_eq_d   = 1'b0;
            br_lt_d   = 1'b0;
          end else begin
            state_d   = S_CMP;
          end
        end
      end
      S_CMP: begin
`ifdef BRANCH_CMP_EARLY_OUT_EN
        if (chunk_gt || chunk_lt || (k_q == '0)) begin
`else
        if (!dec_q && (chunk_gt || chunk_lt)) begin
          dec_d    = 1'b1;
          lt_acc_d = chunk_lt;
        end
        if (k_q == '0) begin
`endif
          state_d   = S_DONE;
          illegal_d = 1'b0;
          br_lt_d   = fin_lt;
          br_eq_d   = fin_eq;
          taken_d   = f3_taken(f3_q, fin_eq, fin_lt);
        end else begin
          k_d = k_q - 1'b1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == S_IDLE) && !rst;
    bus.out_valid = (state_q == S_DONE);
    bus.taken     = taken_q;
    bus.br_eq     = br_eq_q;
    bus.br_lt     = br_lt_q;
    bus.illegal   = illegal_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_branch_cmp_seq.sv
// +-----------------------------------------------------------------------+
// | tb_branch_cmp_seq: directed + randomised scoreboard bench             |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_branch_cmp_seq;
  import branch_pkg::*;

  localparam int XLEN    = 32;
  localparam int N_SWEEP = 1000;

  typedef struct packed {
    logic taken;
    logic eq;
    logic lt;
    logic ill;
  } res_t;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic srst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  res_t q_main[$];

  always #5 clk = ~clk;

  branch_cmp_seq_if #(.XLEN(XLEN)) bi ();
  branch_cmp_seq #(.XLEN(XLEN), .CHUNK(8)) dut (.clk(clk), .rst(rst), .bus(bi));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3);
    res_t r;
    r = '0;
    if (f3 == 3'b010 || f3 == 3'b011) begin
      r.ill = 1'b1;
    end else begin
      r.eq = (a == b);
      r.lt = f3[1] ? (a < b) : ($signed(a) < $signed(b));
      case (f3)
        3'b000:         r.taken = r.eq;
        3'b001:         r.taken = !r.eq;
        3'b100, 3'b110: r.taken = r.lt;
        default:        r.taken = !r.lt;
      endcase
    end
    return r;
  endfunction

  // Edges from the request handshake to the first out_valid sample.
  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] f3, input int ch);
    int nc;
    logic [63:0] m;
    logic [31:0] d;
    nc = 32 / ch;
    m  = (64'd1 << ch) - 64'd1;
    if (f3 == 3'b010 || f3 == 3'b011) return 1;
`ifdef BRANCH_CMP_EARLY_OUT_EN
    for (int k = nc - 1; k >= 0; k--) begin
      d = (a ^ b) >> (k * ch);
      if ((d & m[31:0]) != 32'd0) return nc - k + 1;
    end
`else
    d = '0;
    if (m == 64'd0 && d != 32'd0) return 0;
`endif
    return nc + 1;
  endfunction

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f3, input int hold);
    res_t e, got;
    int   n, lat;
    @(negedge clk);
    n = 0;
    while (!bi.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "/in_ready"}, bi.in_ready, 1);
    bi.in_valid = 1'b1;
    bi.rs1      = a;
    bi.rs2      = b;
    bi.funct3   = f3;
    q_main.push_back(model(a, b, f3));
    lat = exp_lat(a, b, f3, 8);
    @(posedge clk); #1;
    bi.in_valid = 1'b0;
    bi.rs1      = $urandom;
    bi.rs2      = $urandom;
    bi.funct3   = 3'($urandom);
    n = 1;
    while (!bi.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "/latency"}, n, lat);
    chk({tag, "/queue"}, q_main.size(), 1);
    e   = (q_main.size() != 0) ? q_main.pop_front() : '1;
    got = {bi.taken, bi.br_eq, bi.br_lt, bi.illegal};
    chk({tag, "/result"}, got, e);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "/hold_valid"}, bi.out_valid, 1);
      chk({tag, "/hold_ready"}, bi.in_ready, 0);
      chk({tag, "/hold_result"}, {bi.taken, bi.br_eq, bi.br_lt, bi.illegal}, e);
    end
    @(negedge clk);
    bi.out_ready = 1'b1;
    @(posedge clk); #1;
    bi.out_ready = 1'b0;
    chk({tag, "/valid_drop"}, bi.out_valid, 0);
    chk({tag, "/after_result"}, {bi.taken, bi.br_eq, bi.br_lt, bi.illegal}, e);
    chk({tag, "/idle_ready"}, bi.in_ready, 1);
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
    localparam int CH = (gi == 0) ? 1 : (gi == 1) ? 4 : 32;
    branch_cmp_seq_if #(.XLEN(XLEN)) sif ();
    branch_cmp_seq #(.XLEN(XLEN), .CHUNK(CH)) u_dut (.clk(clk), .rst(srst), .bus(sif));
    res_t q[$];
    bit   done = 1'b0;

    initial begin
      logic [31:0] a, b;
      int n_sent, t;
      bit acc;
      n_sent        = 0;
      sif.in_valid  = 1'b0;
      sif.rs1       = '0;
      sif.rs2       = '0;
      sif.funct3    = '0;
      sif.out_ready = 1'b0;
      wait (srst == 1'b0);
      @(posedge clk); #1;
      while (n_sent < N_SWEEP) begin
        @(negedge clk);
        acc = sif.in_valid && sif.in_ready;
        if (acc) begin
          q.push_back(model(sif.rs1, sif.rs2, sif.funct3));
          n_sent++;
        end
        @(posedge clk); #1;
        if (acc || !sif.in_valid) begin
          if ($urandom_range(0, 3) != 0) begin
            a = $urandom;
            case ($urandom_range(0, 3))
              0:       b = a;
              1:       b = a ^ (32'd1 << $urandom_range(0, 31));
              2:       b = (a & 32'hFFFF_FF00) | ($urandom & 32'hFF);
              default: b = $urandom;
            endcase
            sif.in_valid = 1'b1;
            sif.rs1      = a;
            sif.rs2      = b;
            sif.funct3   = 3'($urandom);
          end else begin
            sif.in_valid = 1'b0;
          end
        end
        sif.out_ready = ($urandom_range(0, 3) != 0);
      end
      sif.in_valid  = 1'b0;
      sif.out_ready = 1'b1;
      t = 0;
      while (q.size() != 0 && t < 5000) begin
        @(posedge clk);
        t++;
      end
      chk($sformatf("sweep%0d/drain", CH), q.size(), 0);
      done = 1'b1;
    end

    always @(negedge clk) begin
      if (!srst && sif.out_valid && sif.out_ready) begin
        chk($sformatf("sweep%0d/pending", CH), q.size() != 0, 1);
        if (q.size() != 0) begin
          chk($sformatf("sweep%0d/result", CH),
              {sif.taken, sif.br_eq, sif.br_lt, sif.illegal}, q.pop_front());
        end
      end
    end
  end

  initial begin
    bit seen;
    int t;
    bi.in_valid  = 1'b0;
    bi.rs1       = '0;
    bi.rs2       = '0;
    bi.funct3    = '0;
    bi.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset/out_valid", bi.out_valid, 0);
    chk("reset/outputs", {bi.taken, bi.br_eq, bi.br_lt, bi.illegal}, 4'b0000);
    chk("reset/in_ready", bi.in_ready, 0);
    @(negedge clk);
    rst  = 1'b0;
    srst = 1'b0;
    #1;
    chk("reset/in_ready_release", bi.in_ready, 1);

    do_op("beq_equal",  32'h1234_5678, 32'h1234_5678, F3_BEQ,  0);
    do_op("blt_neg",    32'hFFFF_FFFF, 32'h0000_0001, F3_BLT,  0);
    do_op("bltu_big",   32'hFFFF_FFFF, 32'h0000_0001, F3_BLTU, 0);
    do_op("bgeu_chunk", 32'h0000_0100, 32'h0000_00FF, F3_BGEU, 0);
    do_op("illegal010", 32'h0000_0003, 32'h0000_0004, 3'b010,  3);
    do_op("bge_equal",  32'h8000_0000, 32'h8000_0000, F3_BGE,  1);
    do_op("bne_equal",  32'hA5A5_0000, 32'hA5A5_0000, F3_BNE,  0);
    do_op("illegal011", 32'h0000_0000, 32'h0000_0000, 3'b011,  0);

    // Abort an in-flight compare with reset.
    @(negedge clk);
    bi.in_valid = 1'b1;
    bi.rs1      = 32'h0F0F_0F0F;
    bi.rs2      = 32'h0F0F_0F0F;
    bi.funct3   = F3_BLT;
    @(posedge clk); #1;
    bi.in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort/out_valid", bi.out_valid, 0);
    chk("abort/in_ready_in_rst", bi.in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort/in_ready", bi.in_ready, 1);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen |= bi.out_valid;
    end
    chk("abort/no_result", seen, 0);

    do_op("bne_5_6", 32'd5, 32'd6, F3_BNE, 0);

    t = 0;
    while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) && t < 90000) begin
      @(posedge clk);
      t++;
    end
    chk("sweep/finished", g_sweep[0].done && g_sweep[1].done && g_sweep[2].done, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
